// File: rtl/bf16_bridge_pkg.sv
// Shared definitions for the Wishbone-to-BF16-FPU bridge: register offsets,
// STATUS bit positions and the queued command/result record layouts.
package bf16_bridge_pkg;

  localparam int OP_W_MAX = 8;
  localparam int FLAG_W   = 5;

  localparam logic [7:0] OFF_OPS    = 8'h00;
  localparam logic [7:0] OFF_CMD    = 8'h04;
  localparam logic [7:0] OFF_RESULT = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_IRQ_EN = 8'h10;

  localparam int ST_CMD_FULL  = 8;
  localparam int ST_RES_EMPTY = 9;
  localparam int ST_OVF       = 16;
  localparam int ST_UDF       = 17;
  localparam int ST_SPUR      = 18;

  // The opcode field is sized for the widest supported OP_W; the top uses the low OP_W bits.
  typedef struct packed {
    logic [OP_W_MAX-1:0] op;
    logic [15:0]         a;
    logic [15:0]         b;
  } cmd_t;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [15:0]       res;
  } res_t;

endpackage

// File: rtl/bridge_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is refused when full, pop when empty.
module bridge_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH[AW:0]);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_bf16_fpu_bridge.sv
// Wishbone slave that queues BF16 operations to the FPU and buffers results with credit flow control.
// Define BF16_BRIDGE_IRQ_EN to build the IRQ_EN register and irq_o logic.
module wb_bf16_fpu_bridge
  import bf16_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 4,
  parameter int          OP_W      = 3
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic            fpu_valid_o,
  input  logic            fpu_ready_i,
  output logic [OP_W-1:0] fpu_op_o,
  output logic [15:0]     fpu_a_o,
  output logic [15:0]     fpu_b_o,
  input  logic            fpu_res_valid_i,
  input  logic [15:0]     fpu_res_i,
  input  logic [4:0]      fpu_flags_i,
  output logic            irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   ops;
  logic          ovf, udf, spur;
  logic [CW-1:0] in_flight;
  logic          rd_pop_q;

  logic          hit, req, wr_act;
  logic [7:0]    off;
  logic [31:0]   rdata;

  cmd_t          cmd_in, cmd_head;
  res_t          res_in, res_head;
  logic          cmd_push, cmd_full, cmd_empty;
  logic          res_push, res_full, res_empty;
  logic [CW-1:0] cmd_count, res_count;
  logic [CW:0]   credit_used;
  logic          handshake, res_ok;
  logic          unused;

  assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off    = wbs_adr_i[7:0];
  assign req    = wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;
  // Writes commit at the end of the ack cycle; classic Wishbone holds the bus until then.
  assign wr_act = wbs_ack_o && wbs_cyc_i && wbs_stb_i && wbs_we_i && hit;

  always_comb begin
    cmd_in              = '0;
    cmd_in.op[OP_W-1:0] = wbs_dat_i[OP_W-1:0];
    cmd_in.a            = ops[31:16];
    cmd_in.b            = ops[15:0];
  end

  assign cmd_push = wr_act && (off == OFF_CMD) && wbs_sel_i[0];
  assign res_in   = '{flags: fpu_flags_i, res: fpu_res_i};
  assign res_ok   = fpu_res_valid_i && (in_flight != '0);
  assign res_push = res_ok;

  bridge_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .push(cmd_push), .din(cmd_in), .pop(handshake), .dout(cmd_head),
    .count(cmd_count), .full(cmd_full), .empty(cmd_empty)
  );

  bridge_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(DEPTH)) u_res_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .push(res_push), .din(res_in), .pop(rd_pop_q), .dout(res_head),
    .count(res_count), .full(res_full), .empty(res_empty)
  );

  // A request may only go out if its result is guaranteed a slot in the result FIFO.
  assign credit_used = {1'b0, in_flight} + {1'b0, res_count};
  assign fpu_valid_o = !cmd_empty && (credit_used < DEPTH[CW:0]);
  assign handshake   = fpu_valid_o && fpu_ready_i;
  assign fpu_op_o    = fpu_valid_o ? cmd_head.op[OP_W-1:0] : '0;
  assign fpu_a_o     = fpu_valid_o ? cmd_head.a : '0;
  assign fpu_b_o     = fpu_valid_o ? cmd_head.b : '0;

  assign unused = ^{cmd_head.op, res_full};

`ifdef BF16_BRIDGE_IRQ_EN
  logic [1:0] irq_en;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OPS:    rdata = ops;
      OFF_RESULT: if (!res_empty) rdata = {1'b1, 10'b0, res_head.flags, res_head.res};
      OFF_STATUS: begin
        rdata[3:0]          = 4'(cmd_count);
        rdata[7:4]          = 4'(res_count);
        rdata[ST_CMD_FULL]  = cmd_full;
        rdata[ST_RES_EMPTY] = res_empty;
        rdata[ST_OVF]       = ovf;
        rdata[ST_UDF]       = udf;
        rdata[ST_SPUR]      = spur;
      end
`ifdef BF16_BRIDGE_IRQ_EN
      OFF_IRQ_EN: rdata[1:0] = irq_en;
`endif
      default:    rdata = '0;
    endcase
  end

  // Read data is captured with ack; a successful RESULT read pops at the end of the ack cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ops       <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      spur      <= 1'b0;
      in_flight <= '0;
      rd_pop_q  <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      rd_pop_q  <= 1'b0;
      if (req && !wbs_we_i) begin
        wbs_dat_o <= rdata;
        if (off == OFF_RESULT) begin
          if (res_empty) udf      <= 1'b1;
          else           rd_pop_q <= 1'b1;
        end
      end
      if (wr_act && (off == OFF_OPS)) begin
        for (int i = 0; i < 4; i++)
          if (wbs_sel_i[i]) ops[8*i +: 8] <= wbs_dat_i[8*i +: 8];
      end
      if (wr_act && (off == OFF_STATUS)) begin
        if (wbs_dat_i[ST_OVF])  ovf  <= 1'b0;
        if (wbs_dat_i[ST_UDF])  udf  <= 1'b0;
        if (wbs_dat_i[ST_SPUR]) spur <= 1'b0;
      end
      if (cmd_push && cmd_full)                 ovf  <= 1'b1;
      if (fpu_res_valid_i && (in_flight == '0)) spur <= 1'b1;
      case ({handshake, res_ok})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

`ifdef BF16_BRIDGE_IRQ_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (wr_act && (off == OFF_IRQ_EN)) irq_en <= wbs_dat_i[1:0];
      irq_o <= (irq_en[0] && !res_empty) || (irq_en[1] && (ovf || udf || spur));
    end
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bf16_fpu_bridge.sv
// Directed self-checking bench for wb_bf16_fpu_bridge (DEPTH=4, OP_W=3).
module tb_wb_bf16_fpu_bridge;

`ifdef BF16_BRIDGE_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
  localparam logic [31:0] IRQ_EN_RD = 32'h3;
`else
  localparam logic IRQ_EXP = 1'b0;
  localparam logic [31:0] IRQ_EN_RD = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic        fpu_valid;
  logic        fpu_ready = 1'b0;
  logic [2:0]  fpu_op;
  logic [15:0] fpu_a, fpu_b;
  logic        res_valid = 1'b0;
  logic [15:0] res_val = '0;
  logic [4:0]  res_flags = '0;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_bf16_fpu_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready), .fpu_op_o(fpu_op),
    .fpu_a_o(fpu_a), .fpu_b_o(fpu_b),
    .fpu_res_valid_i(res_valid), .fpu_res_i(res_val), .fpu_flags_i(res_flags),
    .irq_o(irq)
  );

  task automatic wb_access(input logic w, input logic [7:0] off, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
    logic got;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s;
    adr = 32'h3000_0000 | {24'h0, off}; dat_w = d;
    got = 1'b0;
    q = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; q = dat_r; end
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL wb_ack off=%h: ack=0 required 1", off);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] q;
    wb_access(1'b1, off, d, s, q);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] q);
    wb_access(1'b0, off, '0, 4'hF, q);
  endtask

  task automatic do_reset();
    fpu_ready = 1'b0; res_valid = 1'b0; res_val = '0; res_flags = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_result(input logic [15:0] r, input logic [4:0] f);
    @(negedge clk);
    res_valid = 1'b1; res_val = r; res_flags = f;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [69:0] outs;
    logic [31:0] q;
    fpu_ready = 1'b0; res_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    outs = {ack, dat_r, fpu_valid, fpu_op, fpu_a, fpu_b, irq};
    total++;
    if (outs !== '0) begin bad++; $display("[TB] FAIL reset_outputs: got %h required 0", outs); end
    @(negedge clk);
    rst = 1'b0;
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0000_0200) begin bad++; $display("[TB] FAIL reset_status: got %h required 00000200", q); end
    wb_read(8'h00, q);
    total++;
    if (q !== 32'h0) begin bad++; $display("[TB] FAIL reset_ops: got %h required 0", q); end
    wb_read(8'h10, q);
    total++;
    if (q !== 32'h0) begin bad++; $display("[TB] FAIL reset_irq_en: got %h required 0", q); end
  endtask

  task automatic test_registers();
    logic [31:0] q;
    do_reset();
    wb_write(8'h00, 32'hAABB_CCDD, 4'hF);
    wb_write(8'h00, 32'h1122_3344, 4'b0101);
    wb_read(8'h00, q);
    total++;
    if (q !== 32'hAA22_CC44) begin bad++; $display("[TB] FAIL ops_byte_en: got %h required aa22cc44", q); end
    wb_write(8'h20, 32'hFFFF_FFFF, 4'hF);
    wb_read(8'h20, q);
    total++;
    if (q !== 32'h0) begin bad++; $display("[TB] FAIL unmapped_read: got %h required 0", q); end
    wb_write(8'h10, 32'h0000_0003, 4'hF);
    wb_read(8'h10, q);
    total++;
    if (q !== IRQ_EN_RD) begin bad++; $display("[TB] FAIL irq_en_rw: got %h required %h", q, IRQ_EN_RD); end
  endtask

  task automatic test_basic_op();
    logic [31:0] q;
    do_reset();
    fpu_ready = 1'b1;
    wb_write(8'h00, 32'h3F80_4000, 4'hF);
    wb_write(8'h04, 32'h0000_0001, 4'hF);
    total++;
    if ({fpu_valid, fpu_op, fpu_a, fpu_b} !== {1'b1, 3'd1, 16'h3F80, 16'h4000}) begin
      bad++;
      $display("[TB] FAIL issue_payload: got v=%b op=%h a=%h b=%h required v=1 op=1 a=3f80 b=4000",
               fpu_valid, fpu_op, fpu_a, fpu_b);
    end
    pulse_result(16'h4040, 5'h00);
    total++;
    if (fpu_valid !== 1'b0) begin bad++; $display("[TB] FAIL valid_after_issue: got %b required 0", fpu_valid); end
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0000_0010) begin bad++; $display("[TB] FAIL status_one_result: got %h required 00000010", q); end
    wb_read(8'h08, q);
    total++;
    if (q !== 32'h8000_4040) begin bad++; $display("[TB] FAIL result_read: got %h required 80004040", q); end
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0000_0200) begin bad++; $display("[TB] FAIL status_drained: got %h required 00000200", q); end
  endtask

  task automatic test_cmd_overflow();
    logic [31:0] q;
    do_reset();
    wb_write(8'h00, 32'h1234_5678, 4'hF);
    for (int i = 1; i <= 5; i++) begin
      wb_write(8'h04, 32'(i), 4'hF);
      total++;
      if ({fpu_valid, fpu_op, fpu_a, fpu_b} !== {1'b1, 3'd1, 16'h1234, 16'h5678}) begin
        bad++;
        $display("[TB] FAIL held_payload_%0d: got v=%b op=%h a=%h b=%h required v=1 op=1 a=1234 b=5678",
                 i, fpu_valid, fpu_op, fpu_a, fpu_b);
      end
    end
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0001_0304) begin bad++; $display("[TB] FAIL status_overflow: got %h required 00010304", q); end
  endtask

  task automatic test_credit();
    logic [31:0] q;
    do_reset();
    fpu_ready = 1'b1;
    wb_write(8'h00, 32'h4000_4000, 4'hF);
    for (int i = 0; i < 4; i++) wb_write(8'h04, 32'h2, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      res_valid = 1'b1; res_val = 16'h1000 + 16'(i); res_flags = 5'(i);
    end
    @(negedge clk);
    res_valid = 1'b0;
    wb_write(8'h04, 32'h5, 4'hF);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (fpu_valid !== 1'b0) begin bad++; $display("[TB] FAIL credit_blocked: got %b required 0", fpu_valid); end
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0000_0041) begin bad++; $display("[TB] FAIL status_credit: got %h required 00000041", q); end
    total++;
    if (fpu_valid !== 1'b0) begin bad++; $display("[TB] FAIL credit_still_blocked: got %b required 0", fpu_valid); end
    wb_read(8'h08, q);
    total++;
    if (q !== 32'h8000_1000) begin bad++; $display("[TB] FAIL credit_result0: got %h required 80001000", q); end
    total++;
    if ({fpu_valid, fpu_op} !== {1'b1, 3'd5}) begin
      bad++;
      $display("[TB] FAIL credit_release: got v=%b op=%h required v=1 op=5", fpu_valid, fpu_op);
    end
    wb_read(8'h08, q);
    total++;
    if (q !== 32'h8001_1001) begin bad++; $display("[TB] FAIL credit_result1: got %h required 80011001", q); end
  endtask

  task automatic test_underflow();
    logic [31:0] q;
    do_reset();
    wb_read(8'h08, q);
    total++;
    if (q !== 32'h0) begin bad++; $display("[TB] FAIL empty_result: got %h required 0", q); end
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0002_0200) begin bad++; $display("[TB] FAIL status_udf: got %h required 00020200", q); end
    wb_write(8'h0C, 32'h0007_0000, 4'hF);
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0000_0200) begin bad++; $display("[TB] FAIL status_cleared: got %h required 00000200", q); end
  endtask

  task automatic test_spurious_irq();
    logic [31:0] q;
    do_reset();
    wb_write(8'h10, 32'h0000_0002, 4'hF);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_idle: got %b required 0", irq); end
    pulse_result(16'hDEAD, 5'h1F);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_lag: got %b required 0", irq); end
    @(negedge clk);
    total++;
    if (irq !== IRQ_EXP) begin bad++; $display("[TB] FAIL irq_spur: got %b required %b", irq, IRQ_EXP); end
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0004_0200) begin bad++; $display("[TB] FAIL status_spur: got %h required 00040200", q); end
    wb_write(8'h0C, 32'h0004_0000, 4'hF);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_cleared: got %b required 0", irq); end
  endtask

  task automatic test_reset_mid();
    logic [69:0] outs;
    logic [31:0] q;
    do_reset();
    wb_write(8'h00, 32'hABCD_1234, 4'hF);
    wb_write(8'h04, 32'h3, 4'hF);
    wb_write(8'h04, 32'h4, 4'hF);
    total++;
    if ({fpu_valid, fpu_op} !== {1'b1, 3'd3}) begin
      bad++;
      $display("[TB] FAIL pre_reset_valid: got v=%b op=%h required v=1 op=3", fpu_valid, fpu_op);
    end
    @(negedge clk);
    fpu_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    outs = {ack, dat_r, fpu_valid, fpu_op, fpu_a, fpu_b, irq};
    total++;
    if (outs !== '0) begin bad++; $display("[TB] FAIL mid_reset_outputs: got %h required 0", outs); end
    rst = 1'b0;
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0000_0200) begin bad++; $display("[TB] FAIL mid_reset_status: got %h required 00000200", q); end
    pulse_result(16'h4242, 5'h00);
    wb_read(8'h0C, q);
    total++;
    if (q !== 32'h0004_0200) begin bad++; $display("[TB] FAIL late_result_spur: got %h required 00040200", q); end
  endtask

  initial begin
    test_reset();
    test_registers();
    test_basic_op();
    test_cmd_overflow();
    test_credit();
    test_underflow();
    test_spurious_irq();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
